clk_rst_seq: RTL and testbench

Clock/reset sequencer for the system clock tree. It owns the PLL reset, waits for a stable PLL lock, then releases the clock divider reset and the system reset in a fixed order. It recovers automatically from lock loss and lock timeout, and accepts a software reset request. It sits beside the PLL and clock divider in the system control block, runs on the raw board clock, and drives their resets in place of a direct combinational gating of board reset and lock.

---
 rtl/clk_rst_seq.sv | 144 ++++++++++++++
 tb/tb_clk_rst_seq.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/clk_rst_seq.sv
// Clock/reset sequencer: holds the PLL in reset, waits for a stable synchronized
// lock, then releases the clock divider reset and the system reset in order.
module clk_rst_seq #(
  parameter int PLL_RST_CYCLES      = 16,
  parameter int LOCK_STABLE_CYCLES  = 256,
  parameter int DIV_SETTLE_CYCLES   = 8,
  parameter int LOCK_TIMEOUT_CYCLES = 65535
) (
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic       pll_lock_i,
  input  logic       sw_rst_i,
  output logic       pll_rst_o,
  output logic       div_rst_n_o,
  output logic       sys_rst_n_o,
  output logic       ready_o,
  output logic       lock_lost_o,
  output logic [3:0] retry_cnt_o
);

  localparam int MAX_A = (PLL_RST_CYCLES > LOCK_STABLE_CYCLES) ? PLL_RST_CYCLES : LOCK_STABLE_CYCLES;
  localparam int MAX_B = (DIV_SETTLE_CYCLES > LOCK_TIMEOUT_CYCLES) ? DIV_SETTLE_CYCLES : LOCK_TIMEOUT_CYCLES;
  localparam int MAX_P = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int CNT_W = $clog2(MAX_P) + 1;

  localparam logic [CNT_W-1:0] PLL_LAST     = CNT_W'(PLL_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST  = CNT_W'(DIV_SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_PLL_RST   = 2'd0,
    S_WAIT_LOCK = 2'd1,
    S_DIV_RST   = 2'd2,
    S_RUN       = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] stable_q, stable_d;
  logic             sync1_q, lock_s_q;
  logic             lock_lost_q, lock_lost_d;
  logic [3:0]       retry_q, retry_d;
  logic             pll_rst_q, pll_rst_d;
  logic             div_rst_n_q, div_rst_n_d;
  logic             sys_rst_n_q, sys_rst_n_d;
  logic             ready_q, ready_d;
  logic             sw_entry;

  // Two-flop lock synchronizer; resets to "not locked".
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      sync1_q  <= 1'b0;
      lock_s_q <= 1'b0;
    end else begin
      sync1_q  <= pll_lock_i;
      lock_s_q <= sync1_q;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q     <= S_PLL_RST;
      cnt_q       <= '0;
      stable_q    <= '0;
      lock_lost_q <= 1'b0;
      retry_q     <= 4'd0;
      pll_rst_q   <= 1'b1;
      div_rst_n_q <= 1'b0;
      sys_rst_n_q <= 1'b0;
      ready_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      stable_q    <= stable_d;
      lock_lost_q <= lock_lost_d;
      retry_q     <= retry_d;
      pll_rst_q   <= pll_rst_d;
      div_rst_n_q <= div_rst_n_d;
      sys_rst_n_q <= sys_rst_n_d;
      ready_q     <= ready_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    stable_d    = '0;
    lock_lost_d = lock_lost_q;
    retry_d     = retry_q;
    sw_entry    = 1'b0;
    case (state_q)
      S_PLL_RST: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == PLL_LAST) state_d = S_WAIT_LOCK;
      end
      S_WAIT_LOCK: begin
        cnt_d    = cnt_q + CNT_W'(1);
        stable_d = lock_s_q ? stable_q + CNT_W'(1) : '0;
        // Stability is tested first so it wins a tie with the timeout.
        if (lock_s_q && (stable_q == STABLE_LAST)) begin
          state_d = S_DIV_RST;
        end else if (cnt_q == TIMEOUT_LAST) begin
          state_d = S_PLL_RST;
          if (retry_q != 4'hF) retry_d = retry_q + 4'd1;
        end
      end
      S_DIV_RST: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (!lock_s_q)                 state_d = S_PLL_RST;
        else if (cnt_q == SETTLE_LAST) state_d = S_RUN;
      end
      S_RUN: begin
        if (!lock_s_q) begin
          state_d     = S_PLL_RST;
          lock_lost_d = 1'b1;
        end else if (sw_rst_i) begin
          state_d  = S_DIV_RST;
          sw_entry = 1'b1;
        end
      end
      default: state_d = S_PLL_RST;
    endcase

    if (state_d != state_q) begin
      cnt_d    = '0;
      stable_d = '0;
    end

    // Outputs are decoded from the next state so they register with it.
    pll_rst_d   = (state_d == S_PLL_RST);
    div_rst_n_d = (state_d == S_RUN) || ((state_d == S_DIV_RST) && !sw_entry);
    sys_rst_n_d = (state_d == S_RUN);
    ready_d     = (state_d == S_RUN);
  end

  assign pll_rst_o   = pll_rst_q;
  assign div_rst_n_o = div_rst_n_q;
  assign sys_rst_n_o = sys_rst_n_q;
  assign ready_o     = ready_q;
  assign lock_lost_o = lock_lost_q;
  assign retry_cnt_o = retry_q;

endmodule

// File: tb/tb_clk_rst_seq.sv
// Bench for clk_rst_seq: phase/age reference model checked every cycle, plus
// hand-computed timing points for bring-up, glitches, timeout, lock loss and resets.
module tb_clk_rst_seq;

  localparam int P_PLL = 4;
  localparam int P_STB = 8;
  localparam int P_SET = 3;
  localparam int P_TO  = 32;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       pll_lock;
  logic       sw_rst;
  logic       pll_rst_o, div_rst_n_o, sys_rst_n_o, ready_o, lock_lost_o;
  logic [3:0] retry_cnt_o;

  int n_cmp = 0;
  int n_bad = 0;
  bit cmp_en = 1'b0;

  clk_rst_seq #(
    .PLL_RST_CYCLES     (P_PLL),
    .LOCK_STABLE_CYCLES (P_STB),
    .DIV_SETTLE_CYCLES  (P_SET),
    .LOCK_TIMEOUT_CYCLES(P_TO)
  ) dut (
    .clk_i      (clk),
    .rst_n_i    (rst_n),
    .pll_lock_i (pll_lock),
    .sw_rst_i   (sw_rst),
    .pll_rst_o  (pll_rst_o),
    .div_rst_n_o(div_rst_n_o),
    .sys_rst_n_o(sys_rst_n_o),
    .ready_o    (ready_o),
    .lock_lost_o(lock_lost_o),
    .retry_cnt_o(retry_cnt_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: the phase the sequencer is in, how many edges it has
  // spent there, and the current run of consecutive synchronized lock highs.
  localparam int PH_PLL = 0, PH_WAIT = 1, PH_DIV = 2, PH_RUN = 3;
  int ph, age, run1, m_retry;
  bit m_lost, m_swf;
  bit lq[$];

  function automatic void menter(input int p);
    ph = p; age = 0; run1 = 0; m_swf = 1'b0;
  endfunction

  function automatic void mreset();
    menter(PH_PLL);
    m_retry = 0;
    m_lost  = 1'b0;
    lq      = {1'b0, 1'b0};
  endfunction

  function automatic void mstep();
    bit ls;
    ls = lq[0];
    void'(lq.pop_front());
    lq.push_back(pll_lock);
    m_swf = 1'b0;
    age++;
    case (ph)
      PH_PLL: if (age == P_PLL) menter(PH_WAIT);
      PH_WAIT: begin
        run1 = ls ? run1 + 1 : 0;
        if (run1 == P_STB) menter(PH_DIV);
        else if (age == P_TO) begin
          menter(PH_PLL);
          if (m_retry < 15) m_retry++;
        end
      end
      PH_DIV: begin
        if (!ls) menter(PH_PLL);
        else if (age == P_SET) menter(PH_RUN);
      end
      default: begin
        if (!ls) begin
          menter(PH_PLL);
          m_lost = 1'b1;
        end else if (sw_rst) begin
          menter(PH_DIV);
          m_swf = 1'b1;
        end
      end
    endcase
  endfunction

  initial begin
    mreset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) mreset();
      else mstep();
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (cmp_en) begin
        chk("pll_rst_o",   int'(pll_rst_o),   int'(ph == PH_PLL));
        chk("div_rst_n_o", int'(div_rst_n_o), int'(ph == PH_RUN || (ph == PH_DIV && !m_swf)));
        chk("sys_rst_n_o", int'(sys_rst_n_o), int'(ph == PH_RUN));
        chk("ready_o",     int'(ready_o),     int'(ph == PH_RUN));
        chk("lock_lost_o", int'(lock_lost_o), int'(m_lost));
        chk("retry_cnt_o", int'(retry_cnt_o), m_retry);
        chk("inv_sys_implies_div_nopll", int'(sys_rst_n_o && (!div_rst_n_o || pll_rst_o)), 0);
        chk("inv_ready_eq_sys", int'(ready_o), int'(sys_rst_n_o));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
    $fatal(1, "watchdog expired");
  end

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Asserts reset mid-cycle, checks outputs before any edge, releases so the
  // next posedge is edge 1 of the new sequence.
  task automatic do_reset(input logic lk);
    #1 rst_n = 1'b0;
    #1;
    chk("async_pll_rst",   int'(pll_rst_o),   1);
    chk("async_div_rst_n", int'(div_rst_n_o), 0);
    chk("async_sys_rst_n", int'(sys_rst_n_o), 0);
    chk("async_ready",     int'(ready_o),     0);
    chk("async_lock_lost", int'(lock_lost_o), 0);
    chk("async_retry",     int'(retry_cnt_o), 0);
    pll_lock = lk;
    sw_rst   = 1'b0;
    tick(2);
    rst_n = 1'b1;
  endtask

  task automatic bringup_checks();
    tick(3);  chk("up_e3_pll",   int'(pll_rst_o),   1);
    tick(1);  chk("up_e4_pll",   int'(pll_rst_o),   0);
    tick(7);  chk("up_e11_div",  int'(div_rst_n_o), 0);
    tick(1);  chk("up_e12_div",  int'(div_rst_n_o), 1);
              chk("up_e12_sys",  int'(sys_rst_n_o), 0);
    tick(2);  chk("up_e14_sys",  int'(sys_rst_n_o), 0);
    tick(1);  chk("up_e15_sys",  int'(sys_rst_n_o), 1);
              chk("up_e15_rdy",  int'(ready_o),     1);
              chk("up_e15_rtry", int'(retry_cnt_o), 0);
              chk("up_e15_lost", int'(lock_lost_o), 0);
  endtask

  initial begin
    int ed;
    int n;
    rst_n    = 1'b1;
    pll_lock = 1'b0;
    sw_rst   = 1'b0;
    @(posedge clk);
    #1;

    // Clean bring-up
    do_reset(1'b1);
    cmp_en = 1'b1;
    bringup_checks();

    // Software reset from RUN
    tick(2);
    sw_rst = 1'b1;
    tick(1);
    sw_rst = 1'b0;
    chk("sw_sys_drop",  int'(sys_rst_n_o), 0);
    chk("sw_div_first", int'(div_rst_n_o), 0);
    chk("sw_pll_stays", int'(pll_rst_o),   0);
    tick(1); chk("sw_div_up",    int'(div_rst_n_o), 1);
    tick(1); chk("sw_rdy_wait",  int'(ready_o),     0);
    tick(1); chk("sw_rdy_back",  int'(ready_o),     1);

    // One-cycle lock drop in RUN
    tick(2);
    pll_lock = 1'b0;
    tick(1);
    pll_lock = 1'b1;
    chk("loss_e1_sys", int'(sys_rst_n_o), 1);
    tick(1); chk("loss_e2_sys",  int'(sys_rst_n_o), 1);
    tick(1); chk("loss_e3_sys",  int'(sys_rst_n_o), 0);
             chk("loss_e3_pll",  int'(pll_rst_o),   1);
             chk("loss_e3_lost", int'(lock_lost_o), 1);
    tick(14); chk("loss_reseq_rdy0", int'(ready_o),     0);
    tick(1);  chk("loss_reseq_rdy1", int'(ready_o),     1);
              chk("loss_sticky",     int'(lock_lost_o), 1);

    // Async reset while in RUN clears the sticky flag
    tick(3);
    do_reset(1'b1);
    bringup_checks();

    // sw_rst_i and lock loss on the same edge
    tick(2);
    pll_lock = 1'b0;
    tick(2);
    sw_rst = 1'b1;
    chk("both_pre_sys", int'(sys_rst_n_o), 1);
    tick(1);
    sw_rst   = 1'b0;
    pll_lock = 1'b1;
    chk("both_pll",  int'(pll_rst_o),   1);
    chk("both_sys",  int'(sys_rst_n_o), 0);
    chk("both_div",  int'(div_rst_n_o), 0);
    chk("both_lost", int'(lock_lost_o), 1);
    tick(15); chk("both_reseq_rdy", int'(ready_o), 1);

    // Async reset while in DIV_RST
    do_reset(1'b1);
    tick(13);
    chk("div_state_div", int'(div_rst_n_o), 1);
    chk("div_state_sys", int'(sys_rst_n_o), 0);
    do_reset(1'b1);

    // Glitchy lock: runs of 5 never qualify; steady lock exits at edge 30
    tick(5); pll_lock = 1'b0;
    tick(5); pll_lock = 1'b1;
    tick(5); pll_lock = 1'b0;
    tick(5); pll_lock = 1'b1;
    tick(2); chk("glitch_e22_div", int'(div_rst_n_o), 0);
    tick(7); chk("glitch_e29_div", int'(div_rst_n_o), 0);
    tick(1); chk("glitch_e30_div", int'(div_rst_n_o), 1);
    tick(3); chk("glitch_e33_rdy", int'(ready_o),     1);

    // Lock never arrives: retry every 36 cycles, saturating at 15
    do_reset(1'b0);
    tick(35); chk("to_e35_pll",   int'(pll_rst_o),   0);
    tick(1);  chk("to_e36_pll",   int'(pll_rst_o),   1);
              chk("to_e36_retry", int'(retry_cnt_o), 1);
    tick(4);  chk("to_e40_pll",   int'(pll_rst_o),   0);
    ed = 40;
    for (int k = 2; k <= 17; k++) begin
      tick(36 * k - ed);
      ed = 36 * k;
      chk("to_retry", int'(retry_cnt_o), (k > 15) ? 15 : k);
      chk("to_sys",   int'(sys_rst_n_o), 0);
    end

    pll_lock = 1'b1;
    n = 0;
    while (!ready_o && n < 40) begin
      tick(1);
      n++;
    end
    chk("to_recover_ready", int'(ready_o),     1);
    chk("to_recover_retry", int'(retry_cnt_o), 15);

    // Async reset from RUN clears the saturated retry count
    tick(2);
    do_reset(1'b1);
    tick(4);

    cmp_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
